// File: rtl/time_set_ctrl.sv
// Edit-mode controller and per-field increment arbiter in front of the 1 Hz time counter.
// Optional hold-to-repeat on the pushbuttons: define TIME_SET_HOLD_REPEAT_EN.
module time_set_ctrl #(
    parameter int MAX_PEND     = 15,
    parameter int PW           = 4,
    parameter int REPEAT_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slow_tick,
    input  logic       btn_set,
    input  logic       btn_sec,
    input  logic       btn_min,
    input  logic       btn_hour,
    input  logic       edit_key,
    input  logic       left_key,
    input  logic       right_key,
    input  logic       up_key,
    input  logic       down_key,
    output logic       settime,
    output logic       upsec,
    output logic       upmin,
    output logic       uphour,
    output logic [1:0] cursor,
    output logic       busy
);

    localparam logic [1:0]    G_NONE = 2'd0;
    localparam logic [PW+1:0] MAX_W  = (PW+2)'(MAX_PEND);

    if (MAX_PEND > (2**PW) - 1 || MAX_PEND < 1 || REPEAT_TICKS < 0) begin : g_bad_param
        $error("time_set_ctrl: MAX_PEND must be 1..2^PW-1 and REPEAT_TICKS >= 0");
    end

    // bit 3 = set, bits 2:0 = hour/min/sec (field index 0=sec)
    logic [3:0]            sync1, sync2;
    logic [2:0]            sync3;
    logic [2:0]            btn_edge;
    logic                  kb_edit, edit;
    logic [1:0]            cursor_nxt;
    logic [2:0][PW-1:0]    cnt, cnt_nxt;
    logic [2:0][PW+1:0]    sum;
    logic [2:0][1:0]       add;
    logic [2:0]            dec;
    logic [2:0]            rep_fire;
    logic [1:0]            gnt, gnt_nxt, last, last_nxt;
    logic [2:0]            cand_s;
    logic [1:0]            cand;
    logic                  busy_nxt;

`ifdef TIME_SET_HOLD_REPEAT_EN
    localparam int             RW      = $clog2(REPEAT_TICKS + 2);
    localparam logic [RW-1:0]  REP_LIM = RW'(REPEAT_TICKS);
    logic [2:0][RW-1:0] rep_cnt;

    always_comb begin
        for (int f = 0; f < 3; f++)
            rep_fire[f] = edit && sync2[f] && slow_tick && (rep_cnt[f] > REP_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt <= '0;
        end else begin
            for (int f = 0; f < 3; f++) begin
                if (!(edit && sync2[f]))
                    rep_cnt[f] <= '0;
                else if (slow_tick && rep_cnt[f] <= REP_LIM)
                    rep_cnt[f] <= rep_cnt[f] + 1'b1;
            end
        end
    end
`else
    assign rep_fire = 3'b000;
`endif

    assign upsec  = (gnt == 2'd1);
    assign upmin  = (gnt == 2'd2);
    assign uphour = (gnt == 2'd3);

    always_comb begin
        btn_edge   = sync2[2:0] & ~sync3;
        edit       = kb_edit | sync2[3];
        cursor_nxt = cursor;
        if (edit && right_key && !left_key)
            cursor_nxt = (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
        else if (edit && left_key && !right_key)
            cursor_nxt = (cursor == 2'd0) ? 2'd2 : cursor - 2'd1;

        // Post-update counts: decrement of the served field, enqueues, then cancel/flush.
        for (int f = 0; f < 3; f++) begin
            add[f] = {1'b0, edit & btn_edge[f]}
                   + {1'b0, edit & up_key & (cursor == 2'(f))}
                   + {1'b0, rep_fire[f]};
            dec[f] = slow_tick && (gnt == 2'(f + 1)) && (cnt[f] != '0);
            sum[f] = {2'b00, cnt[f]} - {{(PW+1){1'b0}}, dec[f]} + {{PW{1'b0}}, add[f]};
            cnt_nxt[f] = (sum[f] > MAX_W) ? MAX_W[PW-1:0] : sum[f][PW-1:0];
            if ((down_key && cursor == 2'(f)) || !edit)
                cnt_nxt[f] = '0;
        end

        gnt_nxt  = gnt;
        last_nxt = last;
        cand_s   = '0;
        cand     = '0;
        if (slow_tick) begin
            gnt_nxt = G_NONE;
            // walk backwards so the field nearest after 'last' wins
            for (int k = 3; k >= 1; k--) begin
                cand_s = {1'b0, last} + 3'(k);
                cand   = (cand_s >= 3'd3) ? 2'(cand_s - 3'd3) : cand_s[1:0];
                if (cnt_nxt[cand] != '0) begin
                    gnt_nxt  = cand + 2'd1;
                    last_nxt = cand;
                end
            end
        end
        busy_nxt = (cnt_nxt != '0) || (gnt_nxt != G_NONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            sync3   <= '0;
            kb_edit <= 1'b0;
            settime <= 1'b0;
            cursor  <= 2'd0;
            cnt     <= '0;
            gnt     <= G_NONE;
            last    <= 2'd2;
            busy    <= 1'b0;
        end else begin
            sync1   <= {btn_set, btn_hour, btn_min, btn_sec};
            sync2   <= sync1;
            sync3   <= sync2[2:0];
            if (edit_key)
                kb_edit <= ~kb_edit;
            settime <= edit;
            cursor  <= cursor_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            last    <= last_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: grant sequencing, round-robin, saturation, cancel, exit flush, reset.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       slow_tick = 1'b0;
    logic       btn_set = 1'b0, btn_sec = 1'b0, btn_min = 1'b0, btn_hour = 1'b0;
    logic       edit_key = 1'b0, left_key = 1'b0, right_key = 1'b0, up_key = 1'b0, down_key = 1'b0;
    logic       settime, upsec, upmin, uphour, busy;
    logic [1:0] cursor;

    localparam logic [4:0] K_EDIT = 5'b00001, K_LEFT = 5'b00010, K_RIGHT = 5'b00100,
                           K_UP = 5'b01000, K_DOWN = 5'b10000;

    int n_chk = 0;
    int n_err = 0;
    int glog[$];
    int gcode;
    int nhr;
    int exp_rr[4] = '{1, 2, 1, 2};

    time_set_ctrl dut (
        .clk(clk), .reset(reset), .slow_tick(slow_tick),
        .btn_set(btn_set), .btn_sec(btn_sec), .btn_min(btn_min), .btn_hour(btn_hour),
        .edit_key(edit_key), .left_key(left_key), .right_key(right_key),
        .up_key(up_key), .down_key(down_key),
        .settime(settime), .upsec(upsec), .upmin(upmin), .uphour(uphour),
        .cursor(cursor), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Log the grant the counter sees on every slow_tick sample, and check exclusivity.
    always @(negedge clk) begin
        if (slow_tick) begin
            gcode = upsec ? 1 : upmin ? 2 : uphour ? 3 : 0;
            if (gcode != 0) glog.push_back(gcode);
            chk("onehot", 32'($countones({upsec, upmin, uphour}) <= 1), 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kpulse(input logic [4:0] m);
        {down_key, up_key, right_key, left_key, edit_key} = m;
        step();
        {down_key, up_key, right_key, left_key, edit_key} = '0;
    endtask

    task automatic bpulse(input logic [2:0] m);
        {btn_hour, btn_min, btn_sec} = m;
        step(); step();
        {btn_hour, btn_min, btn_sec} = '0;
        step(); step(); step();
    endtask

    task automatic stick();
        slow_tick = 1'b1;
        step();
        slow_tick = 1'b0;
        step(); step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_settime", settime, 0);
        chk("rst_up", {upsec, upmin, uphour}, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_busy", busy, 0);

        // basic grant: 3 increments on seconds
        kpulse(K_EDIT);
        step();
        chk("b_settime", settime, 1);
        repeat (3) kpulse(K_UP);
        chk("b_busy", busy, 1);
        glog.delete();
        stick();
        chk("b_upsec_on", upsec, 1);
        repeat (3) stick();
        chk("b_ngnt", glog.size(), 3);
        foreach (glog[i]) chk("b_gnt", glog[i], 1);
        chk("b_upsec_off", upsec, 0);
        chk("b_busy_off", busy, 0);
        chk("b_settime2", settime, 1);

        // round-robin: 2 sec (buttons) + 2 min (keyboard)
        do_reset();
        kpulse(K_EDIT);
        bpulse(3'b001);
        bpulse(3'b001);
        kpulse(K_RIGHT);
        chk("rr_cursor", cursor, 1);
        kpulse(K_UP);
        kpulse(K_UP);
        glog.delete();
        repeat (5) stick();
        chk("rr_ngnt", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("rr_order", glog[i], exp_rr[i]);
        chk("rr_busy", busy, 0);

        // saturation on hours
        kpulse(K_RIGHT);
        chk("sat_cursor", cursor, 2);
        repeat (20) kpulse(K_UP);
        glog.delete();
        repeat (17) stick();
        nhr = 0;
        foreach (glog[i]) if (glog[i] == 3) nhr++;
        chk("sat_ngnt", glog.size(), 15);
        chk("sat_nhour", nhr, 15);
        chk("sat_busy", busy, 0);

        // cancel with an active grant
        repeat (5) kpulse(K_UP);
        glog.delete();
        stick();
        chk("can_uphour", uphour, 1);
        kpulse(K_DOWN);
        chk("can_hold", uphour, 1);
        repeat (3) stick();
        chk("can_ngnt", glog.size(), 1);
        chk("can_busy", busy, 0);
        chk("can_uphour_off", uphour, 0);

        // cursor wrap
        kpulse(K_RIGHT);
        chk("cur_r_wrap", cursor, 0);
        kpulse(K_LEFT);
        chk("cur_l_wrap", cursor, 2);
        kpulse(K_RIGHT);
        chk("cur_r", cursor, 0);
        kpulse(K_LEFT | K_RIGHT);
        chk("cur_both", cursor, 0);

        // idle: edit off, requests ignored
        kpulse(K_EDIT);
        step();
        chk("idle_settime", settime, 0);
        kpulse(K_UP);
        kpulse(K_RIGHT);
        kpulse(K_LEFT);
        bpulse(3'b111);
        kpulse(K_DOWN);
        chk("idle_cursor", cursor, 0);
        chk("idle_busy", busy, 0);
        glog.delete();
        stick(); stick();
        chk("idle_ngnt", glog.size(), 0);

        // exit flush via btn_set
        btn_set = 1'b1;
        step(); step(); step(); step();
        chk("ex_settime_on", settime, 1);
        kpulse(K_RIGHT);
        repeat (4) kpulse(K_UP);
        glog.delete();
        stick();
        chk("ex_upmin", upmin, 1);
        btn_set = 1'b0;
        step(); step();
        chk("ex_settime_lag", settime, 1);
        step();
        chk("ex_settime_off", settime, 0);
        chk("ex_upmin_hold", upmin, 1);
        chk("ex_busy_hold", busy, 1);
        stick(); stick();
        chk("ex_ngnt", glog.size(), 1);
        chk("ex_upmin_off", upmin, 0);
        chk("ex_busy_off", busy, 0);

        // reset mid-grant
        kpulse(K_EDIT);
        kpulse(K_UP);
        kpulse(K_UP);
        stick();
        chk("mr_upmin", upmin, 1);
        reset = 1'b1;
        step();
        chk("mr_up", {upsec, upmin, uphour}, 0);
        chk("mr_settime", settime, 0);
        chk("mr_cursor", cursor, 0);
        chk("mr_busy", busy, 0);
        step();
        reset = 1'b0;
        step();
        glog.delete();
        stick(); stick();
        chk("mr_ngnt", glog.size(), 0);
        chk("mr_busy2", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Edit-mode controller and request arbiter in front of the 1 Hz time-keeping counter.
- Merges pushbutton requests with PS/2 key pulses from the kb_controller instances.
- Queues per-field increment requests and drives settime/upsec/upmin/uphour so the counter takes at most one increment per 1 Hz sample.
- Exports the edit cursor so the VGA overlay can highlight the selected field.

Parameters:
- MAX_PEND, 15: saturation limit of each per-field pending-increment counter.
- PW, 4: width of each pending counter. MAX_PEND must be ≤ 2^PW−1.
- REPEAT_TICKS, 2: slow_tick count before auto-repeat starts (optional feature only).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- slow_tick  in  1  one-clk strobe in the cycle the counter samples its inputs.
- btn_set  in  1  raw pushbutton; level-held edit request.
- btn_sec  in  1  raw pushbutton; increment-seconds request.
- btn_min  in  1  raw pushbutton; increment-minutes request.
- btn_hour  in  1  raw pushbutton; increment-hours request.
- edit_key  in  1  one-clk keyboard pulse; toggles keyboard edit mode.
- left_key  in  1  one-clk keyboard pulse; moves the cursor left.
- right_key  in  1  one-clk keyboard pulse; moves the cursor right.
- up_key  in  1  one-clk keyboard pulse; enqueues an increment for the cursor field.
- down_key  in  1  one-clk keyboard pulse; cancels pending increments for the cursor field.
- settime  out  1  edit-mode level to the counter.
- upsec  out  1  registered grant to the counter.
- upmin  out  1  registered grant to the counter.
- uphour  out  1  registered grant to the counter.
- cursor  out  2  0=sec, 1=min, 2=hour; never 3.
- busy  out  1  any pending count nonzero or any grant active.

Behaviour:
- Reset values: settime=0, up*=0, cursor=0, busy=0. Reset also clears all pending counters, kb_edit, the round-robin pointer (last served=hour, so sec wins first), and the synchronizers.
- Buttons: 2-FF synchronizer, then a rising-edge detector. Each synchronized rising edge is one request.
- Edit mode:
  - kb_edit toggles on each edit_key pulse.
  - edit = kb_edit OR btn_set_sync.
  - settime is registered edit, so it lags by 1 clk.
- Cursor:
  - Changes only while edit=1.
  - right_key: 0→1→2→0. left_key: 0→2→1→0.
  - left_key and right_key in the same cycle: no move.
- Enqueue:
  - While edit=1, each button edge adds 1 to its own field.
  - While edit=1, up_key adds 1 to the cursor field.
  - Button edge and up_key on the same field in the same cycle add 2.
  - Counts saturate at MAX_PEND; excess requests are dropped silently.
  - Requests arriving while edit=0 are ignored.
- Cancel: down_key sets the cursor field's count to 0 and overrides any enqueue to that field in the same cycle. A grant already driven for that field stays active until the next slow_tick.
- Grant / arbitration:
  - gnt is a 2-bit register: none, sec, min or hour. up* = (gnt==field).
  - gnt changes only in the cycle after a slow_tick, so up* is stable across every counter sample.
  - On a slow_tick cycle:
    1. If gnt≠none, decrement that field's count, floored at 0.
    2. Choose the next gnt round-robin among fields whose post-update count is nonzero, starting after the last served field. Post-update means after the decrement plus any same-cycle enqueues or cancels.
    3. If no field is pending, gnt=none.
  - At most one up* is high at any time. Each request produces exactly one grant, held for exactly one slow_tick.
- Leaving edit (edit falls):
  - Pending counts are flushed to 0 in that cycle.
  - The active grant is held through the next slow_tick, then cleared.
  - settime falls 1 clk after edit falls, independent of the grant.
- busy is registered, equal to (any count≠0 OR gnt≠none).

Optional Feature:
- Macro: TIME_SET_HOLD_REPEAT_EN.
- Defined:
  - Each button holds a per-button repeat counter.
  - While a button stays held and edit=1, count slow_ticks.
  - Once the count exceeds REPEAT_TICKS, enqueue one increment for that field on every subsequent slow_tick.
  - Releasing the button, or edit=0, clears its repeat counter.
- Undefined: only button edges enqueue; no repeat logic is synthesized.

Test Plan:
- Reset check: assert reset 2 clk mid-grant (upmin=1) → next cycle all outputs 0, cursor=0, busy=0; slow_tick afterwards produces no grant.
- Basic grant: edit_key, then 3 up_key at cursor=0 → upsec high for exactly 3 consecutive slow_tick periods, then upsec=0 and busy=0; settime=1 throughout.
- Round-robin arbitration: edit on; 2 btn_sec edges, then right_key, then 2 up_key (min), all before the first slow_tick → grant order sec, min, sec, min; never two up* high together.
- Saturation and cancel: 20 up_key on hour → exactly 15 uphour grants. Refill 5 on hour, then down_key at cursor=2 → at most 1 further grant (the one already active), then busy=0.
- Cursor wrap and idle ignore: from cursor=0, left_key → 2, right_key → 0. With edit=0, key and button pulses change nothing and busy stays 0.
- Exit flush: 4 pending on min, release btn_set (kb_edit=0) → settime falls 1 clk later; at most the already-active upmin grant completes; remaining counts are discarded.
